// File: rtl/ps2_direction_decoder_if.sv
// rtl/ps2_direction_decoder_if.sv - scan-byte input, command queue and status bundle
interface ps2_direction_decoder_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          ps2_key_pressed;
    logic [7:0]                    ps2_key_data;
    logic                          cmd_valid;
    logic [2:0]                    cmd_code;
    logic                          cmd_ready;
    logic [3:0]                    held;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output ps2_key_pressed, ps2_key_data, cmd_ready,
        input  cmd_valid, cmd_code, held, fifo_count, overflow
    );

    modport slave (
        input  ps2_key_pressed, ps2_key_data, cmd_ready,
        output cmd_valid, cmd_code, held, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - set-2 scan bytes to direction/pause command queue; PS2_WASD_EN adds WASD keys
module ps2_direction_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   resetn,
    ps2_direction_decoder_if.slave bus
);
    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t         state;
    logic [TW-1:0]  tmo_cnt;
    logic [3:0]     held;
    logic [2:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           overflow;

    logic           is_ext, is_brk, final_byte, dir_hit, pause_hit;
    logic           make, brk, push, pop, full, wr_en;
    logic [1:0]     dir;
    logic [2:0]     push_code;
    logic [7:0]     data;

    assign data = bus.ps2_key_data;

    always_comb begin
        is_ext     = (state == EXT) || (state == EXT_BRK);
        is_brk     = (state == BRK) || (state == EXT_BRK);
        final_byte = bus.ps2_key_pressed;
        // Prefix bytes only advance the FSM in IDLE/EXT; after F0 any byte completes the sequence.
        if ((state == IDLE || state == EXT) && (data == 8'hE0 || data == 8'hF0))
            final_byte = 1'b0;
        dir_hit   = 1'b0;
        dir       = 2'd0;
        pause_hit = 1'b0;
        if (is_ext) begin
            case (data)
                8'h75:   begin dir_hit = 1'b1; dir = 2'd0; end
                8'h72:   begin dir_hit = 1'b1; dir = 2'd1; end
                8'h6B:   begin dir_hit = 1'b1; dir = 2'd2; end
                8'h74:   begin dir_hit = 1'b1; dir = 2'd3; end
                default: ;
            endcase
        end else begin
            case (data)
                8'h4D:   pause_hit = 1'b1;
`ifdef PS2_WASD_EN
                8'h1D:   begin dir_hit = 1'b1; dir = 2'd0; end
                8'h1B:   begin dir_hit = 1'b1; dir = 2'd1; end
                8'h1C:   begin dir_hit = 1'b1; dir = 2'd2; end
                8'h23:   begin dir_hit = 1'b1; dir = 2'd3; end
`endif
                default: ;
            endcase
        end
        make      = final_byte && !is_brk;
        brk       = final_byte && is_brk;
        push      = make && (pause_hit || (dir_hit && !held[dir]));
        push_code = pause_hit ? 3'd4 : {1'b0, dir};
        full      = (count == DEPTH);
        pop       = bus.cmd_ready && (count != '0);
        wr_en     = push && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            held     <= 4'b0000;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.ps2_key_pressed) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE:    state <= (data == 8'hE0) ? EXT :
                                      (data == 8'hF0) ? BRK : IDLE;
                    EXT:     state <= (data == 8'hF0) ? EXT_BRK :
                                      (data == 8'hE0) ? EXT : IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end

            if (make && dir_hit)
                held[dir] <= 1'b1;
            else if (brk && dir_hit)
                held[dir] <= 1'b0;

            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign bus.cmd_valid  = (count != '0);
    assign bus.cmd_code   = bus.cmd_valid ? mem[rd_ptr] : 3'd0;
    assign bus.held       = held;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - directed bench for ps2_direction_decoder
module tb_ps2_direction_decoder;
    logic clock;
    logic resetn;
    int   total;
    int   bad;

    ps2_direction_decoder_if #(.FIFO_DEPTH(4)) bus ();

    ps2_direction_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(50000)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        @(posedge clock); #1;
        bus.ps2_key_pressed = 1'b1;
        bus.ps2_key_data    = b;
        bus.cmd_ready       = rdy;
        @(posedge clock); #1;
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'h00;
        bus.cmd_ready       = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clock); #1;
        bus.cmd_ready = 1'b1;
        @(posedge clock); #1;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic tap_arrow(input logic [7:0] b);
        send(8'hE0, 1'b0); send(b, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(b, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'h00;
        bus.cmd_ready       = 1'b0;
        #22;
        check("rst_valid", 32'(bus.cmd_valid), 0);
        check("rst_code", 32'(bus.cmd_code), 0);
        check("rst_held", 32'(bus.held), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        @(posedge clock); #1;
        resetn = 1'b1;

        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        check("up_valid", 32'(bus.cmd_valid), 1);
        check("up_code", 32'(bus.cmd_code), 0);
        check("up_held", 32'(bus.held), 32'h1);
        check("up_count", 32'(bus.fifo_count), 1);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        check("up_rel_held", 32'(bus.held), 0);
        check("up_rel_count", 32'(bus.fifo_count), 1);
        pop_one();
        check("pop_count", 32'(bus.fifo_count), 0);
        check("pop_valid", 32'(bus.cmd_valid), 0);

        send(8'hE0, 1'b0); send(8'h6B, 1'b0);
        send(8'hE0, 1'b0); send(8'h6B, 1'b0);
        check("rep_count", 32'(bus.fifo_count), 1);
        check("rep_held", 32'(bus.held), 32'h4);
        check("rep_code", 32'(bus.cmd_code), 2);
        send(8'h4D, 1'b0); send(8'h4D, 1'b0);
        check("pause_count", 32'(bus.fifo_count), 3);
        check("order0", 32'(bus.cmd_code), 2); pop_one();
        check("order1", 32'(bus.cmd_code), 4); pop_one();
        check("order2", 32'(bus.cmd_code), 4); pop_one();
        check("order_empty", 32'(bus.fifo_count), 0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h6B, 1'b0);
        check("left_rel", 32'(bus.held), 0);

        tap_arrow(8'h75); tap_arrow(8'h72); tap_arrow(8'h6B); tap_arrow(8'h74);
        check("fill_count", 32'(bus.fifo_count), 4);
        check("fill_ovf", 32'(bus.overflow), 0);
        send(8'h4D, 1'b0);
        check("ovf_count", 32'(bus.fifo_count), 4);
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_head", 32'(bus.cmd_code), 0);
        check("drain0", 32'(bus.cmd_code), 0); pop_one();
        check("drain1", 32'(bus.cmd_code), 1); pop_one();
        check("drain2", 32'(bus.cmd_code), 2); pop_one();
        check("drain3", 32'(bus.cmd_code), 3); pop_one();
        check("drain_empty", 32'(bus.cmd_valid), 0);
        check("ovf_sticky", 32'(bus.overflow), 1);

        do_reset();
        check("rst2_ovf", 32'(bus.overflow), 0);
        tap_arrow(8'h75); tap_arrow(8'h72); tap_arrow(8'h6B); tap_arrow(8'h74);
        send(8'h4D, 1'b1);
        check("fullpp_count", 32'(bus.fifo_count), 4);
        check("fullpp_ovf", 32'(bus.overflow), 0);
        check("fullpp_d0", 32'(bus.cmd_code), 1); pop_one();
        check("fullpp_d1", 32'(bus.cmd_code), 2); pop_one();
        check("fullpp_d2", 32'(bus.cmd_code), 3); pop_one();
        check("fullpp_d3", 32'(bus.cmd_code), 4); pop_one();
        check("fullpp_empty", 32'(bus.fifo_count), 0);

        send(8'hE0, 1'b0);
        repeat (60000) @(posedge clock);
        send(8'h75, 1'b0);
        check("tmo_count", 32'(bus.fifo_count), 0);
        check("tmo_held", 32'(bus.held), 0);
        send(8'hE0, 1'b0);
        repeat (100) @(posedge clock);
        send(8'h75, 1'b0);
        check("short_wait_count", 32'(bus.fifo_count), 1);
        check("short_wait_held", 32'(bus.held), 32'h1);

        send(8'hE0, 1'b0);
        resetn = 1'b0;
        #2;
        check("mid_rst_valid", 32'(bus.cmd_valid), 0);
        check("mid_rst_code", 32'(bus.cmd_code), 0);
        check("mid_rst_held", 32'(bus.held), 0);
        check("mid_rst_count", 32'(bus.fifo_count), 0);
        check("mid_rst_ovf", 32'(bus.overflow), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        send(8'h74, 1'b0);
        check("mid_rst_74_count", 32'(bus.fifo_count), 0);
        check("mid_rst_74_held", 32'(bus.held), 0);

        send(8'h4D, 1'b1);
        check("empty_pp_count", 32'(bus.fifo_count), 1);
        check("empty_pp_code", 32'(bus.cmd_code), 4);
        pop_one();

`ifdef PS2_WASD_EN
        send(8'h1D, 1'b0);
        check("w_code", 32'(bus.cmd_code), 0);
        check("w_held", 32'(bus.held), 32'h1);
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        check("w_arrow_count", 32'(bus.fifo_count), 1);
        send(8'hF0, 1'b0); send(8'h1D, 1'b0);
        check("w_rel_held", 32'(bus.held), 0);
`else
        send(8'h1D, 1'b0);
        check("w_ignored_count", 32'(bus.fifo_count), 0);
        check("w_ignored_held", 32'(bus.held), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Sits directly downstream of the PS2 keyboard interface and upstream of the processor's input path.
- Consumes raw set-2 scan-code bytes and tracks the make/break/extended prefix sequence.
- Converts direction and pause key presses into a queue of game commands, one per key press.
- Also exposes a live held-key mask for continuous-movement logic.

Parameters:
- FIFO_DEPTH, 4: command queue entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: idle cycles after a prefix byte before the FSM abandons the sequence (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- ps2_key_pressed  in  1  single-cycle strobe: a new scan byte is present.
- ps2_key_data  in  8  scan byte, valid when ps2_key_pressed=1.
- cmd_valid  out  1  queue non-empty.
- cmd_code  out  3  head command: 0 up, 1 down, 2 left, 3 right, 4 pause; valid while cmd_valid=1.
- cmd_ready  in  1  consumer pops the head this cycle; ignored when cmd_valid=0.
- held  out  4  one-hot-per-bit held mask: [0] up, [1] down, [2] left, [3] right.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a command was dropped because the queue was full.

Behaviour:
- Reset (async, resetn=0): FSM to IDLE; queue emptied; cmd_valid=0, cmd_code=0, held=0, fifo_count=0, overflow=0; timeout counter=0. Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Bytes are processed only on ps2_key_pressed.
  - IDLE: E0 -> EXT; F0 -> BRK; otherwise decode as a normal make, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; otherwise decode as an extended make -> IDLE.
  - BRK: decode as a normal break -> IDLE.
  - EXT_BRK: decode as an extended break -> IDLE.
- Extended keys: 75 up, 72 down, 6B left, 74 right.
- Normal keys: 4D (P) pause.
- Unrecognised codes are ignored; the state transition still occurs.
- Timeout: in EXT, BRK or EXT_BRK, the counter increments each cycle with no strobe. At TIMEOUT_CYCLES it returns to IDLE with no side effect. The counter clears on every strobe and in IDLE.
- Make of a direction key:
  - If the held bit is clear: set it and push the command.
  - If the bit is already set (typematic repeat): no push, no change.
- Make of pause: push code 4 on every make, repeats included. No held bit.
- Break of a direction key: clear its held bit; never pushes. Break of pause: no effect.
- Latency: strobe in cycle N -> held and queue updated at edge N+1; cmd_valid visible in cycle N+1.
- Queue: show-ahead FIFO. cmd_code always equals the head entry. Pop occurs on cmd_ready & cmd_valid.
- Simultaneous push and pop: both take effect, including when full (no drop, count unchanged) and when empty-plus-push (pop ignored because cmd_valid=0).
- Push when full without pop: command dropped, overflow set to 1. overflow clears only on reset. Read/write pointers wrap modulo FIFO_DEPTH.
- fifo_count arithmetic: +1 on push-only, -1 on pop-only, unchanged otherwise; never exceeds FIFO_DEPTH.

Optional Feature:
- Macro PS2_WASD_EN.
- Defined: normal-key makes/breaks 1D (W) up, 1B (S) down, 1C (A) left, 23 (D) right. These share held bits and repeat suppression with the arrow keys; a break of either source for a direction clears the shared bit.
- Undefined: 1D/1B/1C/23 are treated as unrecognised and ignored.

Test Plan:
- Bytes E0,75 -> one cycle after the 75 strobe: cmd_valid=1, cmd_code=0, held=4'b0001, fifo_count=1. Then E0,F0,75 -> held=0, fifo_count still 1.
- E0,6B then E0,6B again (repeat) with no break -> exactly one entry, code 2. Then 4D twice -> count=3, codes 2,4,4 in order.
- Fill queue with 4 distinct presses (up/down/left/right, releasing each between) with cmd_ready=0, then press P -> count=4, overflow=1, head code 0. Repeat fill-to-full but press P with cmd_ready=1 in the same cycle -> count stays 4, no overflow.
- E0 strobe, then 60000 idle cycles, then 75 -> 75 decoded as a normal make (unrecognised): no push, held=0.
- Assert resetn=0 between E0 and 74 -> after release, the 74 byte alone causes no push; all outputs are 0 during reset.
- With PS2_WASD_EN: 1D -> code 0, held[0]=1; E0,75 -> no push; F0,1D -> held[0]=0. Without the macro, 1D -> no push.
